mem_access_master: RTL and testbench
====================================

MEM_ACCESS_MASTER -- requirements
Module: mem_access_master

Interface
REQ-001 SHALL use a single clock; reset is asynchronous and active-low (ports clk, reset_n).
REQ-002 Parameter TIMEOUT, default 16, meaning: max cycles waiting for MOC before abort.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 req  input  1  control-unit request; sampled only in IDLE.
REQ-006 rw  input  1  1=read, 0=write (same encoding as RAM ReadWrite).
REQ-007 size  input  1  0=word, 1=byte.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data; byte stores use wdata[7:0].
REQ-010 busy  output  1  high from accepted req until return to IDLE.
REQ-011 done  output  1  one-cycle pulse on successful completion.
REQ-012 err  output  1  one-cycle pulse on misalignment or timeout.
REQ-013 rdata  output  32  load result; held until next accepted read.
REQ-014 mem_en, mem_rw, mem_size  output  1 each  RAM Enable, ReadWrite, size.
REQ-015 mem_addr, mem_din  output  32 each  RAM Address, DataIn.
REQ-016 mem_mov  output  1  memory-operation-valid to RAM.
REQ-017 mem_moc  input  1  memory-operation-complete from RAM.
REQ-018 mem_dout  input  32  RAM DataOut.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RELEASE.
REQ-020 IDLE: req=1 latches rw, size, addr, wdata into internal registers; word request with addr[1:0]!=0 pulses err next cycle, stays IDLE, never asserts mem_mov.
REQ-021 IDLE->ISSUE on valid req; ISSUE drives mem_en=1, mem_rw, mem_size, mem_addr, mem_din from latched values, mem_mov=0 (one cycle address/data setup).
REQ-022 ISSUE->WAIT unconditionally; WAIT holds bus values and asserts mem_mov=1.
REQ-023 WAIT with mem_moc=1: read captures rdata (word: mem_dout; byte: {24'b0, mem_dout[7:0]}), drops mem_mov, pulses done, -> RELEASE.
REQ-024 WAIT timeout: cycle counter reaching TIMEOUT without mem_moc SHALL drop mem_mov, pulse err, -> RELEASE; rdata unchanged.
REQ-025 RELEASE: mem_mov=0, mem_en held; -> IDLE when mem_moc=0, deasserting mem_en.
REQ-026 Minimum latency SHALL be: req accepted at edge N, ISSUE at N+1, WAIT at N+2, done at edge after first mem_moc=1 sample.
REQ-027 req during busy SHALL be ignored (no queueing); control unit holds req until done/err.
REQ-028 done and err SHALL never assert in the same cycle.
REQ-029 Timeout counter SHALL be $clog2(TIMEOUT+1) bits, cleared on entry to WAIT, saturating.
REQ-030 mem_moc already high on WAIT entry SHALL complete in the first WAIT cycle.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, busy=0, done=0, err=0, mem_en=0, mem_mov=0, mem_rw=1, mem_size=0, mem_addr=0, mem_din=0, rdata=0, counter=0.
REQ-032 Reset mid-transfer SHALL abort without done/err pulse; first post-reset req behaves as from power-up.

Structure
REQ-033 Shared package SHALL hold the state enum, RW_READ/RW_WRITE, SIZE_WORD/SIZE_BYTE constants.
REQ-034 Timeout counter SHALL be sub-module mem_timeout_counter (clear, enable, expired).

Verification
REQ-035 Word read addr=40, RAM model MOC after 2 cycles, dout=0xE7D12000 -> rdata=0xE7D12000, one done pulse, busy 5 cycles.
REQ-036 Byte write addr=0x13, wdata=0xAB -> mem_size=1, mem_din[7:0]=0xAB, mem_rw=0 stable while mem_mov=1, done pulse.
REQ-037 Word read addr=0x22 -> err pulse next cycle, mem_mov never asserted, busy stays 0.
REQ-038 RAM never raises MOC -> err after 16 WAIT cycles, mem_mov dropped, rdata keeps prior value.
REQ-039 reset_n low during WAIT -> all outputs at reset values same cycle, no done/err.
REQ-040 Byte read addr=3, mem_dout=0x123456C4 -> rdata=0x000000C4; back-to-back req during busy ignored.

Source files
------------

// File: rtl/mem_access_master_pkg.sv
`default_nettype none
// mem_access_master_pkg -- FSM state encoding, RAM bus encodings and request helpers.
// Rev 1.0
package mem_access_master_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;
  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  function automatic logic is_misaligned(input logic sz, input logic [1:0] addr_lsb);
    return (sz == SIZE_WORD) && (addr_lsb != 2'b00);
  endfunction

  function automatic logic [31:0] load_extract(input logic sz, input logic [31:0] dout);
    return (sz == SIZE_BYTE) ? {24'b0, dout[7:0]} : dout;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// mem_timeout_counter -- saturating cycle counter bounding the wait for MOC.
// Rev 1.0
module mem_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Asserted during the TIMEOUT-th enabled cycle, the one whose edge brings the count to TIMEOUT.
  assign expired = enable && (count_q >= CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_master.sv
`default_nettype none
// mem_access_master -- single-outstanding RAM access sequencer (IDLE/ISSUE/WAIT/RELEASE)
// with word-alignment check and MOC timeout. Rev 1.0
module mem_access_master
  import mem_access_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        rw,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_mov,
  input  logic        mem_moc,
  input  logic [31:0] mem_dout
);

  logic [1:0]  state_q, state_d;
  logic        rw_q, rw_d;
  logic        size_q, size_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tmo_expired;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == ST_ISSUE),
    .enable  (state_q == ST_WAIT),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          rw_d    = rw;
          size_d  = size;
          addr_d  = addr;
          wdata_d = wdata;
          // A misaligned word access is rejected here and never reaches the bus.
          if (is_misaligned(size, addr[1:0])) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_moc) begin
          done_d  = 1'b1;
          state_d = ST_RELEASE;
          if (rw_q == RW_READ) begin
            rdata_d = load_extract(size_q, mem_dout);
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!mem_moc) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rw_q    <= RW_READ;
      size_q  <= SIZE_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign mem_en   = (state_q != ST_IDLE);
  assign mem_mov  = (state_q == ST_WAIT);
  assign mem_rw   = rw_q;
  assign mem_size = size_q;
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_master.sv
`timescale 1ns/1ps
`default_nettype none
// tb_mem_access_master -- randomized bench with a RAM responder and a transaction-level model.
module tb_mem_access_master;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0, rw = 1'b1, size = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, err, mem_en, mem_rw, mem_size, mem_mov, mem_moc;
  logic [31:0] rdata, mem_addr, mem_din, mem_dout;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .rw(rw), .size(size), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_mov(mem_mov), .mem_moc(mem_moc), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // RAM responder: MOC rises ram_lat cycles after MOV, lingers ram_hold cycles after MOV drops.
  int          ram_lat = 2, ram_hold = 0, mov_cnt = 0, hold_cnt = 0;
  logic [31:0] ram_dout = '0, noise = '0;
  assign mem_moc  = (mem_mov && (mov_cnt >= ram_lat)) || (hold_cnt > 0);
  assign mem_dout = (mem_mov && mem_moc) ? ram_dout : noise;
  always @(posedge clk) begin
    mov_cnt <= mem_mov ? mov_cnt + 1 : 0;
    if (mem_mov && mem_moc) hold_cnt <= ram_hold;
    else if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
  end
  always @(negedge clk) noise = $urandom;

  // Observations of one transaction
  int          o_busy, o_mov, o_done, o_err, o_both, o_bus_bad, o_first_mov, o_done_at;
  bit          o_hung;
  logic        o_size_seen;
  logic [31:0] o_din_seen;

  // Expected values from the transaction-level model
  int          e_busy, e_mov, e_done, e_err, e_first_mov, e_done_at;
  logic [31:0] exp_rdata = '0;

  task automatic predict(input logic t_rw, input logic t_size, input logic [31:0] t_addr,
                         input int lat, input int hold, input logic [31:0] dout);
    int wait_c;
    bit ok;
    if (t_size == 1'b0 && (t_addr % 4) != 0) begin
      e_err = 1; e_done = 0; e_busy = 0; e_mov = 0; e_first_mov = -1; e_done_at = -1;
    end else begin
      ok          = (lat + 1 <= TIMEOUT);
      wait_c      = ok ? lat + 1 : TIMEOUT;
      e_mov       = wait_c;
      e_first_mov = 2;
      e_done      = ok ? 1 : 0;
      e_err       = ok ? 0 : 1;
      e_busy      = 1 + wait_c + (ok ? 1 + hold : 1);
      e_done_at   = ok ? 2 + wait_c : -1;
      if (ok && t_rw) exp_rdata = t_size ? (dout & 32'hFF) : dout;
    end
  endtask

  task automatic run_txn(input logic t_rw, input logic t_size, input logic [31:0] t_addr,
                         input logic [31:0] t_wdata, input int lat, input int hold,
                         input logic [31:0] dout, input bit spam);
    bit finished = 0;
    int post = 0;
    ram_lat = lat; ram_hold = hold; ram_dout = dout;
    o_busy = 0; o_mov = 0; o_done = 0; o_err = 0; o_both = 0; o_bus_bad = 0;
    o_first_mov = -1; o_done_at = -1; o_hung = 1; o_size_seen = 1'bx; o_din_seen = 'x;
    @(negedge clk);
    req = 1'b1; rw = t_rw; size = t_size; addr = t_addr; wdata = t_wdata;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      if (busy) o_busy++;
      if (mem_en !== busy) o_bus_bad++;
      if (mem_mov) begin
        o_mov++;
        if (o_first_mov < 0) o_first_mov = cyc;
        o_size_seen = mem_size; o_din_seen = mem_din;
        if (mem_addr !== t_addr || mem_rw !== t_rw || mem_size !== t_size || mem_din !== t_wdata)
          o_bus_bad++;
      end
      if (done) begin o_done++; if (o_done_at < 0) o_done_at = cyc; end
      if (err) o_err++;
      if (done && err) o_both++;
      if (done || err) finished = 1;
      if (finished) req = 1'b0;
      else if (spam && busy) begin
        req = 1'($urandom_range(0, 1)); rw = 1'($urandom); size = 1'($urandom);
        addr = $urandom; wdata = $urandom;
      end
      if (finished && !busy) post++;
      if (post >= 3) begin o_hung = 0; break; end
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({busy, done, err, mem_en, mem_mov, mem_rw, mem_size} !== 7'b0000010) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b required 0000010",
               {busy, done, err, mem_en, mem_mov, mem_rw, mem_size});
    end
    n_cmp++;
    if ({mem_addr, mem_din, rdata} !== 96'd0) begin
      n_bad++;
      $display("FAIL reset_data: got addr=%h din=%h rdata=%h required all zero", mem_addr, mem_din, rdata);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_word_read();
    predict(1'b1, 1'b0, 32'd40, 2, 0, 32'hE7D12000);
    run_txn(1'b1, 1'b0, 32'd40, 32'h0, 2, 0, 32'hE7D12000, 1'b0);
    n_cmp++; if (o_hung) begin n_bad++; $display("FAIL wr_hang: transaction did not finish"); end
    n_cmp++; if (rdata !== 32'hE7D12000) begin n_bad++; $display("FAIL wr_rdata: got %h required e7d12000", rdata); end
    n_cmp++; if (o_done !== 1 || o_err !== 0) begin n_bad++; $display("FAIL wr_pulses: done=%0d err=%0d required 1/0", o_done, o_err); end
    n_cmp++; if (o_busy !== 5) begin n_bad++; $display("FAIL wr_busy: got %0d required 5", o_busy); end
    n_cmp++; if (o_first_mov !== e_first_mov || o_done_at !== e_done_at) begin
      n_bad++; $display("FAIL wr_latency: mov@%0d done@%0d required %0d/%0d", o_first_mov, o_done_at, e_first_mov, e_done_at);
    end
  endtask

  task automatic test_byte_write();
    predict(1'b0, 1'b1, 32'h13, 1, 0, 32'h0);
    run_txn(1'b0, 1'b1, 32'h13, 32'h5A5A_5AAB, 1, 0, 32'h0, 1'b0);
    n_cmp++; if (o_size_seen !== 1'b1 || o_din_seen[7:0] !== 8'hAB) begin
      n_bad++; $display("FAIL bw_bus: size=%b din=%h required 1/..ab", o_size_seen, o_din_seen);
    end
    n_cmp++; if (o_bus_bad !== 0) begin n_bad++; $display("FAIL bw_stable: got %0d bad bus cycles required 0", o_bus_bad); end
    n_cmp++; if (o_done !== e_done || o_busy !== e_busy) begin
      n_bad++; $display("FAIL bw_done: done=%0d busy=%0d required %0d/%0d", o_done, o_busy, e_done, e_busy);
    end
    n_cmp++; if (rdata !== exp_rdata) begin n_bad++; $display("FAIL bw_rdata: got %h required %h", rdata, exp_rdata); end
  endtask

  task automatic test_misaligned();
    predict(1'b1, 1'b0, 32'h22, 2, 0, 32'h1);
    run_txn(1'b1, 1'b0, 32'h22, 32'h0, 2, 0, 32'h1, 1'b0);
    n_cmp++; if (o_err !== 1 || o_done !== 0) begin n_bad++; $display("FAIL mis_pulses: err=%0d done=%0d required 1/0", o_err, o_done); end
    n_cmp++; if (o_mov !== 0 || o_busy !== 0) begin n_bad++; $display("FAIL mis_bus: mov=%0d busy=%0d required 0/0", o_mov, o_busy); end
    n_cmp++; if (rdata !== exp_rdata) begin n_bad++; $display("FAIL mis_rdata: got %h required %h", rdata, exp_rdata); end
  endtask

  task automatic test_timeout();
    predict(1'b1, 1'b0, 32'h100, 1000, 0, 32'hDEAD_BEEF);
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 1000, 0, 32'hDEAD_BEEF, 1'b0);
    n_cmp++; if (o_err !== 1 || o_done !== 0) begin n_bad++; $display("FAIL to_pulses: err=%0d done=%0d required 1/0", o_err, o_done); end
    n_cmp++; if (o_mov !== TIMEOUT) begin n_bad++; $display("FAIL to_mov: got %0d required %0d", o_mov, TIMEOUT); end
    n_cmp++; if (o_busy !== e_busy) begin n_bad++; $display("FAIL to_busy: got %0d required %0d", o_busy, e_busy); end
    n_cmp++; if (rdata !== exp_rdata) begin n_bad++; $display("FAIL to_rdata: got %h required %h", rdata, exp_rdata); end
  endtask

  task automatic test_moc_early();
    predict(1'b1, 1'b0, 32'h44, 0, 0, 32'h0BAD_F00D);
    run_txn(1'b1, 1'b0, 32'h44, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0);
    n_cmp++; if (o_mov !== 1 || o_done_at !== e_done_at) begin
      n_bad++; $display("FAIL early_wait: mov=%0d done@%0d required 1/%0d", o_mov, o_done_at, e_done_at);
    end
    n_cmp++; if (rdata !== exp_rdata) begin n_bad++; $display("FAIL early_rdata: got %h required %h", rdata, exp_rdata); end
  endtask

  task automatic test_release_hold();
    predict(1'b0, 1'b0, 32'h80, 3, 3, 32'h0);
    run_txn(1'b0, 1'b0, 32'h80, 32'h1234_5678, 3, 3, 32'h0, 1'b0);
    n_cmp++; if (o_busy !== e_busy || o_bus_bad !== 0) begin
      n_bad++; $display("FAIL rel_hold: busy=%0d badbus=%0d required %0d/0", o_busy, o_bus_bad, e_busy);
    end
  endtask

  task automatic test_back_to_back();
    predict(1'b1, 1'b1, 32'h3, 4, 1, 32'h1234_56C4);
    run_txn(1'b1, 1'b1, 32'h3, 32'h0, 4, 1, 32'h1234_56C4, 1'b1);
    n_cmp++; if (rdata !== 32'h0000_00C4) begin n_bad++; $display("FAIL b2b_rdata: got %h required 000000c4", rdata); end
    n_cmp++; if (o_done !== 1 || o_err !== 0 || o_bus_bad !== 0) begin
      n_bad++; $display("FAIL b2b_ignore: done=%0d err=%0d badbus=%0d required 1/0/0", o_done, o_err, o_bus_bad);
    end
    n_cmp++; if (o_busy !== e_busy) begin n_bad++; $display("FAIL b2b_busy: got %0d required %0d", o_busy, e_busy); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    bit reached = 0;
    ram_lat = 1000; ram_hold = 0;
    @(negedge clk);
    req = 1'b1; rw = 1'b0; size = 1'b0; addr = 32'h0000_0F00; wdata = 32'hCAFE_0001;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_mov) begin reached = 1; break; end
    end
    n_cmp++; if (!reached) begin n_bad++; $display("FAIL rm_reach: WAIT not reached, mov=%b required 1", mem_mov); end
    #2; reset_n = 1'b0; #1;
    n_cmp++;
    if ({busy, done, err, mem_en, mem_mov, mem_rw, mem_size} !== 7'b0000010 || {mem_addr, mem_din, rdata} !== 96'd0) begin
      n_bad++;
      $display("FAIL rm_outputs: ctrl=%b addr=%h din=%h rdata=%h required 0000010/0/0/0",
               {busy, done, err, mem_en, mem_mov, mem_rw, mem_size}, mem_addr, mem_din, rdata);
    end
    req = 1'b0;
    exp_rdata = '0;
    repeat (3) begin @(posedge clk); #1; if (done || err) pulses++; end
    @(negedge clk); reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (done || err) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rm_pulse: got %0d pulses required 0", pulses); end
    predict(1'b1, 1'b0, 32'h0000_0F00, 2, 0, 32'h7777_1111);
    run_txn(1'b1, 1'b0, 32'h0000_0F00, 32'h0, 2, 0, 32'h7777_1111, 1'b0);
    n_cmp++; if (o_done !== 1 || o_busy !== e_busy || rdata !== exp_rdata) begin
      n_bad++; $display("FAIL rm_after: done=%0d busy=%0d rdata=%h required 1/%0d/%h", o_done, o_busy, rdata, e_busy, exp_rdata);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      logic        t_rw, t_size;
      logic [31:0] t_addr, t_wdata, t_dout;
      int          lat, hold;
      t_rw    = 1'($urandom);
      t_size  = 1'($urandom);
      t_addr  = $urandom;
      if (!t_size && $urandom_range(0, 3) != 0) t_addr = t_addr & 32'hFFFF_FFFC;
      t_wdata = $urandom;
      t_dout  = $urandom;
      lat     = $urandom_range(0, 20);
      hold    = $urandom_range(0, 2);
      predict(t_rw, t_size, t_addr, lat, hold, t_dout);
      run_txn(t_rw, t_size, t_addr, t_wdata, lat, hold, t_dout, 1'($urandom));
      n_cmp++; if (o_hung) begin n_bad++; $display("FAIL rnd%0d_hang: no completion", k); end
      n_cmp++; if (o_done !== e_done || o_err !== e_err) begin
        n_bad++; $display("FAIL rnd%0d_pulses: done=%0d err=%0d required %0d/%0d", k, o_done, o_err, e_done, e_err);
      end
      n_cmp++; if (o_both !== 0) begin n_bad++; $display("FAIL rnd%0d_both: got %0d required 0", k, o_both); end
      n_cmp++; if (o_busy !== e_busy || o_mov !== e_mov) begin
        n_bad++; $display("FAIL rnd%0d_timing: busy=%0d mov=%0d required %0d/%0d", k, o_busy, o_mov, e_busy, e_mov);
      end
      n_cmp++; if (o_first_mov !== e_first_mov || o_done_at !== e_done_at) begin
        n_bad++; $display("FAIL rnd%0d_latency: mov@%0d done@%0d required %0d/%0d", k, o_first_mov, o_done_at, e_first_mov, e_done_at);
      end
      n_cmp++; if (o_bus_bad !== 0) begin n_bad++; $display("FAIL rnd%0d_bus: got %0d bad cycles required 0", k, o_bus_bad); end
      n_cmp++; if (rdata !== exp_rdata) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h required %h", k, rdata, exp_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_misaligned();
    test_timeout();
    test_moc_early();
    test_release_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
